// File: rtl/inst_encode.sv
// inst_encode: packs decoded RV32I fields into instruction words
// two-stage valid/ready pipeline, word address stamping, error count
module inst_encode #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        clear,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [6:0]  opcode,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [2:0]  funct3,
   input  logic [6:0]  funct7,
   input  logic [31:0] imm,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_inst,
   output logic [31:0] out_addr,
   output logic        out_err,
   output logic [15:0] err_count
);

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_S     = 7'b0100011;
   localparam logic [6:0] OP_B     = 7'b1100011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_IMM   = 7'b0010011;

   logic        s1_valid_q, s1_valid_d;
   logic [6:0]  op_q;
   logic [4:0]  rd_q;
   logic [4:0]  rs1_q;
   logic [4:0]  rs2_q;
   logic [2:0]  f3_q;
   logic [6:0]  f7_q;
   logic [31:0] imm_q;

   logic        s2_valid_q, s2_valid_d;
   logic [31:0] inst_q, inst_d;
   logic        err_q, err_d;
   logic [31:0] addr_q, addr_d;
   logic [15:0] cnt_q, cnt_d;

   logic        in_xfer;
   logic        out_xfer;
   logic        s1_adv;
   logic        fits12;
   logic        fits13;
   logic        fits21;
   logic [31:0] enc_inst;
   logic        enc_err;

   assign out_valid = s2_valid_q & ~clear;
   assign out_xfer  = out_valid & out_ready;
   assign s1_adv    = ~s2_valid_q | out_xfer;
   assign in_ready  = ~clear & (~s1_valid_q | s1_adv);
   assign in_xfer   = in_valid & in_ready;

   assign out_inst  = inst_q;
   assign out_err   = err_q;
   assign out_addr  = addr_q;
   assign err_count = cnt_q;

   // an immediate fits N bits when all bits above N-1 copy the sign
   assign fits12 = (&imm_q[31:11]) | ~(|imm_q[31:11]);
   assign fits13 = (&imm_q[31:12]) | ~(|imm_q[31:12]);
   assign fits21 = (&imm_q[31:20]) | ~(|imm_q[31:20]);

   // pick the format from the opcode and pack the word in S1
   always_comb begin
      enc_inst = {imm_q[11:0], rs1_q, f3_q, rd_q, op_q};
      enc_err  = ~fits12;
      unique case (op_q)
         OP_R: begin
            enc_inst = {f7_q, rs2_q, rs1_q, f3_q, rd_q, op_q};
            enc_err  = 1'b0;
         end
         OP_S: begin
            enc_inst = {imm_q[11:5], rs2_q, rs1_q, f3_q,
                        imm_q[4:0], op_q};
            enc_err  = ~fits12;
         end
         OP_B: begin
            enc_inst = {imm_q[12], imm_q[10:5], rs2_q, rs1_q,
                        f3_q, imm_q[4:1], imm_q[11], op_q};
            enc_err  = imm_q[0] | ~fits13;
         end
         OP_LUI, OP_AUIPC: begin
            enc_inst = {imm_q[31:12], rd_q, op_q};
            enc_err  = |imm_q[11:0];
         end
         OP_JAL: begin
            enc_inst = {imm_q[20], imm_q[10:1], imm_q[11],
                        imm_q[19:12], rd_q, op_q};
            enc_err  = imm_q[0] | ~fits21;
         end
         OP_IMM: begin
            if (f3_q == 3'b001 || f3_q == 3'b101) begin
               enc_inst = {f7_q, imm_q[4:0], rs1_q, f3_q, rd_q, op_q};
               enc_err  = |imm_q[31:5];
            end
         end
         default: ;
      endcase
      // non-32-bit opcodes keep the I-format word but are flagged
      if (op_q[1:0] != 2'b11)
         enc_err = 1'b1;
   end

   // next state for both stages, the address and the error count
   always_comb begin
      s1_valid_d = s1_valid_q;
      s2_valid_d = s2_valid_q;
      inst_d     = inst_q;
      err_d      = err_q;
      addr_d     = addr_q;
      cnt_d      = cnt_q;
      if (s1_adv)
         s1_valid_d = 1'b0;
      if (in_xfer)
         s1_valid_d = 1'b1;
      if (s1_adv) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            inst_d = enc_inst;
            err_d  = enc_err;
         end
      end
      if (out_xfer) begin
         addr_d = addr_q + 32'd4;
         if (err_q && cnt_q != 16'hFFFF)
            cnt_d = cnt_q + 16'd1;
      end
      if (clear) begin
         s1_valid_d = 1'b0;
         s2_valid_d = 1'b0;
         inst_d     = 32'd0;
         err_d      = 1'b0;
         addr_d     = BASE_ADDR;
         cnt_d      = 16'd0;
      end
   end

   // S1 field capture on every accepted input
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         op_q  <= 7'd0;
         rd_q  <= 5'd0;
         rs1_q <= 5'd0;
         rs2_q <= 5'd0;
         f3_q  <= 3'd0;
         f7_q  <= 7'd0;
         imm_q <= 32'd0;
      end else if (in_xfer) begin
         op_q  <= opcode;
         rd_q  <= rd;
         rs1_q <= rs1;
         rs2_q <= rs2;
         f3_q  <= funct3;
         f7_q  <= funct7;
         imm_q <= imm;
      end
   end

   // pipeline valids, output word, address and error counter
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         inst_q     <= 32'd0;
         err_q      <= 1'b0;
         addr_q     <= BASE_ADDR;
         cnt_q      <= 16'd0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
         inst_q     <= inst_d;
         err_q      <= err_d;
         addr_q     <= addr_d;
         cnt_q      <= cnt_d;
      end
   end

endmodule
